// File: rtl/board_led_scanner_pkg.sv
// ---------------------------------------------------------------------------
// board_led_scanner_pkg
//   Definitions shared by connect_four, board_rw and board_led_scanner:
//   player/cell codes, read-port address width, default board geometry, the
//   scanner FSM state type and the LED colour helper.
// ---------------------------------------------------------------------------
package board_led_scanner_pkg;

    localparam int DEFAULT_COLS = 8;
    localparam int DEFAULT_ROWS = 8;
    localparam int ADDR_W       = 3;   // width of the core's row/col read address

    // Cell contents as returned by the core's read port.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PLAYER1 = 2'b01,
        PLAYER2 = 2'b10
    } player_t;

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_FETCH,
        ST_SHOW
    } scan_state_t;

    typedef struct packed {
        logic red;
        logic green;
    } led_pair_t;

    // Player 1 is red, player 2 is green. The undefined code 11 lights both
    // dies so a corrupted cell is visible rather than silently dark.
    function automatic led_pair_t cell_colour(input logic [1:0] code);
        led_pair_t p;
        p = '0;
        case (code)
            PLAYER1: p.red   = 1'b1;
            PLAYER2: p.green = 1'b1;
            2'b11: begin
                p.red   = 1'b1;
                p.green = 1'b1;
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/board_led_scanner_scan_timer.sv
// ---------------------------------------------------------------------------
// scan_timer
//   Timing half of the LED scanner: the per-line hold down-counter, the line
//   counter (0..ROWS, where ROWS is the cursor line), the frame counter and
//   the blink phase derived from it.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   hold_load    in   load the hold counter (first SHOW cycle follows)
//   line_adv     in   advance to the next line (last SHOW cycle)
//   hold_done    out  hold counter has reached its final cycle
//   line         out  line currently being fetched/shown
//   cursor_line  out  line == ROWS
//   blink_phase  out  frame_cnt[BLINK_LOG2-1]; 0 = blinking items dark
// ---------------------------------------------------------------------------
module scan_timer #(
    parameter int ROWS        = 8,
    parameter int HOLD_CYCLES = 1024,
    parameter int BLINK_LOG2  = 5,
    parameter int LINE_W      = $clog2(ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_load,
    input  logic              line_adv,
    output logic              hold_done,
    output logic [LINE_W-1:0] line,
    output logic              cursor_line,
    output logic              blink_phase
);

    localparam logic [15:0]       HOLD_LAST   = 16'(HOLD_CYCLES - 1);
    localparam logic [LINE_W-1:0] CURSOR_LINE = LINE_W'(ROWS);

    logic [15:0]           hold_cnt_q;
    logic [BLINK_LOG2-1:0] frame_cnt_q;

    // Loaded with HOLD_CYCLES-1 so that SHOW lasts exactly HOLD_CYCLES cycles
    // including the cycle in which the count reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (hold_load) begin
            hold_cnt_q <= HOLD_LAST;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line        <= '0;
            frame_cnt_q <= '0;
        end else if (line_adv) begin
            if (line == CURSOR_LINE) begin
                line        <= '0;
                frame_cnt_q <= frame_cnt_q + BLINK_LOG2'(1);
            end else begin
                line <= line + LINE_W'(1);
            end
        end
    end

    assign hold_done   = (hold_cnt_q == '0);
    assign cursor_line = (line == CURSOR_LINE);
    assign blink_phase = frame_cnt_q[BLINK_LOG2-1];

endmodule

// File: rtl/board_led_scanner.sv
// ---------------------------------------------------------------------------
// board_led_scanner
//   Display stage for the connect-four core. Reads each board row through the
//   core's top read port into a shadow register, then lights it on a
//   row-multiplexed red/green LED matrix. After the ROWS board lines a cursor
//   line shows the drop column in the current player's colour, or the whole
//   line flashing in the winner's colour. Winning cells blink.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   rd_row/col   out  board read address (valid during FETCH)
//   rd_data/win  in   cell contents / winning flag, one cycle after address
//   board_busy   in   core owns the read port; rd_data invalid
//   cur_col      in   current drop column
//   cur_player   in   player to move
//   winner       in   00 none, else winning player
//   row_sel      out  one-hot line enable (bit ROWS = cursor line)
//   led_red      out  red column drive
//   led_green    out  green column drive
//   frame_start  out  one-cycle pulse when line 0 lights
// ---------------------------------------------------------------------------
module board_led_scanner
    import board_led_scanner_pkg::*;
#(
    parameter int COLS        = DEFAULT_COLS,
    parameter int ROWS        = DEFAULT_ROWS,
    parameter int HOLD_CYCLES = 1024,
    parameter int BLINK_LOG2  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [2:0]        rd_row,
    output logic [2:0]        rd_col,
    input  logic [1:0]        rd_data,
    input  logic              rd_win,
    input  logic              board_busy,
    input  logic [2:0]        cur_col,
    input  logic [1:0]        cur_player,
    input  logic [1:0]        winner,
    output logic [ROWS:0]     row_sel,
    output logic [COLS-1:0]   led_red,
    output logic [COLS-1:0]   led_green,
    output logic              frame_start
);

    localparam int LINE_W = $clog2(ROWS + 1);
    localparam int K_W    = $clog2(COLS + 1);
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [K_W-1:0] K_LAST  = K_W'(COLS);
    localparam logic [ROWS:0]  SEL_ONE = (ROWS + 1)'(1);

    scan_state_t state_q, state_d;

    logic [K_W-1:0]         k_q;
    logic [COL_W-1:0]       cap_idx;
    logic                   k_clear, k_inc, capture, shadow_clear;
    logic                   show_enter, show_exit;

    logic [COLS-1:0][1:0]   shadow_data_q, fetched_data;
    logic [COLS-1:0]        shadow_win_q, fetched_win;
    logic [COLS-1:0]        red_d, green_d;

    logic [LINE_W-1:0]      line;
    logic                   cursor_line, blink_phase, hold_done;

    scan_timer #(
        .ROWS        (ROWS),
        .HOLD_CYCLES (HOLD_CYCLES),
        .BLINK_LOG2  (BLINK_LOG2),
        .LINE_W      (LINE_W)
    ) u_scan_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold_load   (show_enter),
        .line_adv    (show_exit),
        .hold_done   (hold_done),
        .line        (line),
        .cursor_line (cursor_line),
        .blink_phase (blink_phase)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and datapath controls
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first; a missing
    // assignment on any path would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        k_clear      = 1'b0;
        k_inc        = 1'b0;
        capture      = 1'b0;
        shadow_clear = 1'b0;
        show_enter   = 1'b0;
        show_exit    = 1'b0;

        case (state_q)
            ST_BLANK: begin
                k_clear = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (cursor_line) begin
                    // No board reads; cursor inputs are sampled on this edge.
                    show_enter = 1'b1;
                    state_d    = ST_SHOW;
                end else if (board_busy) begin
                    // Read port hijacked: anything fetched so far may mix
                    // old and new board state, so the whole line restarts.
                    k_clear      = 1'b1;
                    shadow_clear = 1'b1;
                end else begin
                    // Data for column k-1 arrives while column k is addressed.
                    capture = (k_q != '0);
                    if (k_q == K_LAST) begin
                        show_enter = 1'b1;
                        state_d    = ST_SHOW;
                    end else begin
                        k_inc = 1'b1;
                    end
                end
            end

            ST_SHOW: begin
                if (hold_done) begin
                    show_exit = 1'b1;
                    state_d   = ST_BLANK;
                end
            end

            default: state_d = ST_BLANK;
        endcase
    end

    assign rd_row  = cursor_line ? '0 : ADDR_W'(line);
    assign rd_col  = (k_q < K_LAST) ? ADDR_W'(k_q) : '0;
    assign cap_idx = COL_W'(k_q - K_W'(1));

    // Shadow with this cycle's capture merged in, so the final column can be
    // shown on the same edge that captures it.
    always_comb begin
        fetched_data = shadow_data_q;
        fetched_win  = shadow_win_q;
        if (capture) begin
            fetched_data[cap_idx] = rd_data;
            fetched_win[cap_idx]  = rd_win;
        end
    end

    // ------------------------------------------------------------------
    // Colour mapping for the line about to be shown
    // ------------------------------------------------------------------
    always_comb begin
        led_pair_t px;
        red_d   = '0;
        green_d = '0;
        for (int c = 0; c < COLS; c++) begin
            px = '0;
            if (cursor_line) begin
                if (winner == EMPTY) begin
                    if (cur_col == ADDR_W'(c)) begin
                        px = cell_colour(cur_player);
                    end
                end else if (blink_phase) begin
                    px = cell_colour(winner);
                end
            end else if (!(fetched_win[c] && !blink_phase)) begin
                px = cell_colour(fetched_data[c]);
            end
            red_d[c]   = px.red;
            green_d[c] = px.green;
        end
    end

    // ------------------------------------------------------------------
    // Fetch counter, shadow and output registers
    // ------------------------------------------------------------------
    // NOTE: the shadow is a handful of flops, so it is reset with everything
    // else; that keeps the first frame after reset deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q           <= '0;
            shadow_data_q <= '0;
            shadow_win_q  <= '0;
            row_sel       <= '0;
            led_red       <= '0;
            led_green     <= '0;
            frame_start   <= 1'b0;
        end else begin
            if (k_clear) begin
                k_q <= '0;
            end else if (k_inc) begin
                k_q <= k_q + K_W'(1);
            end

            if (shadow_clear) begin
                shadow_data_q <= '0;
                shadow_win_q  <= '0;
            end else begin
                shadow_data_q <= fetched_data;
                shadow_win_q  <= fetched_win;
            end

            frame_start <= show_enter && (line == '0);

            // Lines are dark in BLANK/FETCH so a row switch never shows the
            // previous line's columns.
            if (show_enter) begin
                row_sel   <= SEL_ONE << line;
                led_red   <= red_d;
                led_green <= green_d;
            end else if (show_exit) begin
                row_sel   <= '0;
                led_red   <= '0;
                led_green <= '0;
            end
        end
    end

endmodule
